// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO-fed FM0 backscatter transmitter.
package fifo_tx_pkg;

  localparam int unsigned HalfBitCycDefault = 4;
  localparam int unsigned DataWDefault      = 8;

  // FM0 symbol constants: idle line level, the data value that toggles mid-bit,
  // and the trailing dummy bit value.
  localparam logic Fm0LineIdle  = 1'b0;
  localparam logic Fm0MidToggle = 1'b0;
  localparam logic Fm0DummyBit  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StSend,
    StEof,
    StDone
  } tx_state_e;

endpackage

// File: rtl/fm0_bit_encoder.sv
// FM0 line encoder: owns the half-bit timer and the line level for one bit at a time.
module fm0_bit_encoder
  import fifo_tx_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYC = HalfBitCycDefault
) (
  input  logic r_clk,
  input  logic reset,
  input  logic clear_i,
  input  logic bit_i,
  input  logic bit_start_i,
  output logic tx_out_o,
  output logic bit_end_o
);

  localparam int unsigned CntW = $clog2(HALF_BIT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(HALF_BIT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            half_q, half_d;
  logic            bit_q, bit_d;
  logic            level_q, level_d;
  logic            run_q, run_d;

  always_ff @(posedge r_clk) begin
    if (reset) begin
      cnt_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= 1'b0;
      level_q <= Fm0LineIdle;
      run_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      level_q <= level_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    half_d  = half_q;
    bit_d   = bit_q;
    level_d = level_q;
    run_d   = run_q;
    if (clear_i) begin
      cnt_d   = '0;
      half_d  = 1'b0;
      bit_d   = 1'b0;
      level_d = Fm0LineIdle;
      run_d   = 1'b0;
    end else if (bit_start_i) begin
      // Every FM0 bit begins with a transition.
      level_d = ~level_q;
      cnt_d   = '0;
      half_d  = 1'b0;
      bit_d   = bit_i;
      run_d   = 1'b1;
    end else if (run_q) begin
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        half_d = 1'b1;
        if (!half_q && (bit_q == Fm0MidToggle)) begin
          level_d = ~level_q;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign tx_out_o  = level_q;
  assign bit_end_o = run_q && half_q && (cnt_q == CntLast);

endmodule

// File: rtl/fifo_fm0_tx.sv
// Frame transmitter: pops FIFO words, shifts them out MSB first through the FM0
// encoder with a one-word prefetch, and closes each frame with a dummy data-1 bit.
module fifo_fm0_tx
  import fifo_tx_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYC = HalfBitCycDefault,
  parameter int unsigned DATA_W       = DataWDefault
) (
  input  logic              r_clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              tx_out,
  output logic              tx_active,
  output logic              done
);

  localparam int unsigned BitCntW = $clog2(DATA_W);
  localparam logic [BitCntW-1:0] LastBit     = BitCntW'(DATA_W - 1);
  localparam logic [BitCntW-1:0] PrefetchBit = BitCntW'(DATA_W - 2);

  tx_state_e          state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  next_q, next_d;
  logic               have_next_q, have_next_d;
  logic               cap_q, cap_d;
  logic               read_q, read_d;

  logic enc_start, enc_bit, enc_clear, enc_tx_out, bit_end;

  fm0_bit_encoder #(
    .HALF_BIT_CYC(HALF_BIT_CYC)
  ) u_enc (
    .r_clk      (r_clk),
    .reset      (reset),
    .clear_i    (enc_clear),
    .bit_i      (enc_bit),
    .bit_start_i(enc_start),
    .tx_out_o   (enc_tx_out),
    .bit_end_o  (bit_end)
  );

  always_ff @(posedge r_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      next_q      <= '0;
      have_next_q <= 1'b0;
      cap_q       <= 1'b0;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      next_q      <= next_d;
      have_next_q <= have_next_d;
      cap_q       <= cap_d;
      read_q      <= read_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = fifo_empty ? StDone : StFetch;
      StFetch: state_d = StLoad;
      StLoad:  state_d = StSend;
      StSend:  if (bit_end && (bit_cnt_q == LastBit) && !have_next_q) state_d = StEof;
      StEof:   if (bit_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!en) state_d = StIdle;
  end

  // Datapath, prefetch and encoder control.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    next_d      = next_q;
    have_next_d = have_next_q;
    cap_d       = read_q;
    read_d      = 1'b0;
    enc_start   = 1'b0;
    enc_bit     = shift_q[DATA_W-1];
    unique case (state_q)
      StIdle: begin
        read_d      = start && !fifo_empty;
        bit_cnt_d   = '0;
        have_next_d = 1'b0;
      end
      StLoad: begin
        enc_start = 1'b1;
        enc_bit   = fifo_data[DATA_W-1];
        shift_d   = fifo_data;
        bit_cnt_d = '0;
      end
      StSend: begin
        if (cap_q) begin
          next_d      = fifo_data;
          have_next_d = 1'b1;
        end
        if (bit_end) begin
          enc_start = 1'b1;
          if (bit_cnt_q == LastBit) begin
            if (have_next_q) begin
              shift_d     = next_q;
              enc_bit     = next_q[DATA_W-1];
              bit_cnt_d   = '0;
              have_next_d = 1'b0;
            end else begin
              enc_bit = Fm0DummyBit;
            end
          end else begin
            shift_d   = shift_q << 1;
            enc_bit   = shift_q[DATA_W-2];
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Registered read lands in the first cycle of the word's last bit.
            read_d    = (bit_cnt_q == PrefetchBit) && !fifo_empty;
          end
        end
      end
      default: ;
    endcase
    if (!en) begin
      read_d      = 1'b0;
      cap_d       = 1'b0;
      have_next_d = 1'b0;
      enc_start   = 1'b0;
    end
    enc_clear = (state_d == StIdle) || (state_d == StDone);
  end

  always_comb begin
    fifo_read = read_q;
    tx_out    = enc_tx_out;
    tx_active = (state_q == StFetch) || (state_q == StLoad) ||
                (state_q == StSend) || (state_q == StEof);
    done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_fifo_fm0_tx.sv
// Directed bench for fifo_fm0_tx with a simple FIFO model and an FM0 reference.
module tb_fifo_fm0_tx;

  localparam int unsigned HB = 4;
  localparam int unsigned DW = 8;

  logic          r_clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read, tx_out, tx_active, done;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem[32];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] pend_word = '0;
  logic          pend_vld = 1'b0;
  int            read_cnt = 0;
  int            read_empty_cnt = 0;
  int            done_cnt = 0;

  logic exp_half[$];
  logic exp_lvl;

  always #5 r_clk = ~r_clk;

  fifo_fm0_tx #(
    .HALF_BIT_CYC(HB),
    .DATA_W      (DW)
  ) dut (
    .r_clk     (r_clk),
    .reset     (reset),
    .en        (en),
    .start     (start),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .tx_out    (tx_out),
    .tx_active (tx_active),
    .done      (done)
  );

  // FIFO model: data appears the cycle after the read strobe.
  always @(negedge r_clk) begin
    if (pend_vld) begin
      fifo_data = pend_word;
      pend_vld  = 1'b0;
    end
    if (fifo_read === 1'b1) begin
      read_cnt++;
      if (rd_ptr == wr_ptr) begin
        read_empty_cnt++;
      end else begin
        pend_word = mem[rd_ptr];
        rd_ptr++;
        pend_vld = 1'b1;
      end
    end
    if (done === 1'b1) done_cnt++;
    fifo_empty = (rd_ptr == wr_ptr);
  end

  task automatic next_cycle();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  function automatic void model_clear();
    exp_half.delete();
    exp_lvl = 1'b0;
  endfunction

  function automatic void model_bit(input logic b);
    exp_lvl = ~exp_lvl;
    exp_half.push_back(exp_lvl);
    if (!b) exp_lvl = ~exp_lvl;
    exp_half.push_back(exp_lvl);
  endfunction

  function automatic void model_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) model_bit(w[i]);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    repeat (3) next_cycle();
    total += 4;
    if (tx_out !== 1'b0) begin bad++; $display("FAIL reset_tx_out got=%b exp=0", tx_out); end
    if (fifo_read !== 1'b0) begin bad++; $display("FAIL reset_fifo_read got=%b exp=0", fifo_read); end
    if (tx_active !== 1'b0) begin bad++; $display("FAIL reset_tx_active got=%b exp=0", tx_active); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_a5();
    logic [17:0] pat;
    int          r0;
    pat = 18'b110100101011010011;
    r0  = read_cnt;
    push_word(8'hA5);
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    total += 3;
    if (fifo_read !== 1'b1) begin bad++; $display("FAIL a5_read_c1 got=%b exp=1", fifo_read); end
    if (tx_active !== 1'b1) begin bad++; $display("FAIL a5_active_c1 got=%b exp=1", tx_active); end
    next_cycle();
    if (fifo_read !== 1'b0) begin bad++; $display("FAIL a5_read_c2 got=%b exp=0", fifo_read); end
    for (int c = 0; c < 72; c++) begin
      next_cycle();
      total += 2;
      if (tx_out !== pat[17 - c / HB]) begin
        bad++;
        $display("FAIL a5_tx_out cyc=%0d got=%b exp=%b", c + 3, tx_out, pat[17 - c / HB]);
      end
      if (tx_active !== 1'b1) begin
        bad++;
        $display("FAIL a5_active cyc=%0d got=%b exp=1", c + 3, tx_active);
      end
    end
    next_cycle();
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL a5_done_c75 got=%b exp=1", done); end
    if (tx_active !== 1'b0) begin bad++; $display("FAIL a5_active_c75 got=%b exp=0", tx_active); end
    next_cycle();
    total += 3;
    if (done !== 1'b0) begin bad++; $display("FAIL a5_done_c76 got=%b exp=0", done); end
    if (tx_out !== 1'b0) begin bad++; $display("FAIL a5_idle_tx got=%b exp=0", tx_out); end
    if (read_cnt - r0 != 1) begin bad++; $display("FAIL a5_reads got=%0d exp=1", read_cnt - r0); end
  endtask

  task automatic test_back_to_back();
    int r0;
    int e0;
    r0 = read_cnt;
    e0 = read_empty_cnt;
    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h3C);
    model_clear();
    model_word(8'h00);
    model_word(8'hFF);
    model_word(8'h3C);
    model_bit(1'b1);
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    for (int c = 0; c < 200; c++) begin
      next_cycle();
      total += 2;
      if (tx_out !== exp_half[c / HB]) begin
        bad++;
        $display("FAIL b2b_tx_out cyc=%0d got=%b exp=%b", c + 3, tx_out, exp_half[c / HB]);
      end
      if (tx_active !== 1'b1) begin
        bad++;
        $display("FAIL b2b_active cyc=%0d got=%b exp=1", c + 3, tx_active);
      end
    end
    next_cycle();
    total += 3;
    if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
    if (read_cnt - r0 != 3) begin bad++; $display("FAIL b2b_reads got=%0d exp=3", read_cnt - r0); end
    if (read_empty_cnt != e0) begin
      bad++;
      $display("FAIL b2b_read_empty got=%0d exp=%0d", read_empty_cnt, e0);
    end
    next_cycle();
  endtask

  task automatic test_empty_start();
    int r0;
    r0 = read_cnt;
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    total += 3;
    if (done !== 1'b1) begin bad++; $display("FAIL empty_done_c1 got=%b exp=1", done); end
    if (fifo_read !== 1'b0) begin bad++; $display("FAIL empty_read got=%b exp=0", fifo_read); end
    if (tx_out !== 1'b0) begin bad++; $display("FAIL empty_tx_out got=%b exp=0", tx_out); end
    next_cycle();
    total += 2;
    if (done !== 1'b0) begin bad++; $display("FAIL empty_done_c2 got=%b exp=0", done); end
    if (read_cnt != r0) begin bad++; $display("FAIL empty_reads got=%0d exp=0", read_cnt - r0); end
  endtask

  task automatic test_en_drop();
    int r0;
    int d0;
    r0 = read_cnt;
    push_word(8'h5A);
    push_word(8'h81);
    push_word(8'hC3);
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (28) next_cycle();
    // Now in cycle 29, inside bit 3 of the first word.
    d0 = done_cnt;
    en = 1'b0;
    next_cycle();
    total += 4;
    if (tx_out !== 1'b0) begin bad++; $display("FAIL endrop_tx_out got=%b exp=0", tx_out); end
    if (fifo_read !== 1'b0) begin bad++; $display("FAIL endrop_read got=%b exp=0", fifo_read); end
    if (tx_active !== 1'b0) begin bad++; $display("FAIL endrop_active got=%b exp=0", tx_active); end
    if (done !== 1'b0) begin bad++; $display("FAIL endrop_done got=%b exp=0", done); end
    next_cycle();
    en = 1'b1;
    repeat (4) next_cycle();
    total += 2;
    if (done_cnt != d0) begin bad++; $display("FAIL endrop_no_done got=%0d exp=0", done_cnt - d0); end
    if (read_cnt - r0 != 1) begin bad++; $display("FAIL endrop_reads got=%0d exp=1", read_cnt - r0); end
    model_clear();
    model_word(8'h81);
    model_word(8'hC3);
    model_bit(1'b1);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    for (int c = 0; c < 136; c++) begin
      next_cycle();
      total++;
      if (tx_out !== exp_half[c / HB]) begin
        bad++;
        $display("FAIL resume_tx_out cyc=%0d got=%b exp=%b", c + 3, tx_out, exp_half[c / HB]);
      end
    end
    next_cycle();
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL resume_done got=%b exp=1", done); end
    if (read_cnt - r0 != 3) begin bad++; $display("FAIL resume_reads got=%0d exp=3", read_cnt - r0); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = read_cnt;
    push_word(8'h33);
    push_word(8'h44);
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (57) next_cycle();
    // Cycle 58: the prefetch decision cycle of the first word.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    total += 5;
    if (tx_out !== 1'b0) begin bad++; $display("FAIL rstmid_tx_out got=%b exp=0", tx_out); end
    if (fifo_read !== 1'b0) begin bad++; $display("FAIL rstmid_read got=%b exp=0", fifo_read); end
    if (tx_active !== 1'b0) begin bad++; $display("FAIL rstmid_active got=%b exp=0", tx_active); end
    if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    if (read_cnt - r0 != 1) begin bad++; $display("FAIL rstmid_reads got=%0d exp=1", read_cnt - r0); end
    next_cycle();
  endtask

  task automatic test_start_held();
    int r0;
    int d0;
    r0 = read_cnt;
    d0 = done_cnt;
    // FIFO still holds 0x44 left over from the mid-frame reset.
    model_clear();
    model_word(8'h44);
    model_bit(1'b1);
    start = 1'b1;
    next_cycle();
    total++;
    if (fifo_read !== 1'b1) begin bad++; $display("FAIL held_read_c1 got=%b exp=1", fifo_read); end
    next_cycle();
    for (int c = 0; c < 72; c++) begin
      next_cycle();
      total++;
      if (tx_out !== exp_half[c / HB]) begin
        bad++;
        $display("FAIL held_tx_out cyc=%0d got=%b exp=%b", c + 3, tx_out, exp_half[c / HB]);
      end
    end
    next_cycle();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL held_done_c75 got=%b exp=1", done); end
    start = 1'b0;
    repeat (8) next_cycle();
    total += 2;
    if (read_cnt - r0 != 1) begin bad++; $display("FAIL held_reads got=%0d exp=1", read_cnt - r0); end
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL held_dones got=%0d exp=1", done_cnt - d0); end
  endtask

  initial begin
    exp_lvl = 1'b0;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_empty_start();
    test_en_drop();
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
